prime_seq_ctrl: RTL and testbench
=================================

# prime_seq_ctrl

Sequencer that finds the N-th prime by driving a shared trial-division prime checker through a request/acknowledge handshake. It sits between the user front end (debounced buttons that select N and trigger start, LEDs that show the result) and the prime-checker datapath. It walks candidates upward from 2, counts checker-confirmed primes, and returns the N-th one. It reports overflow if the candidate range runs out first.

## Interface
Parameters:
- W, 8: candidate/result width in bits.
- IDX_W, 4: width of the requested index N.

Ports:
- clk  in  1  the single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  active-high command pulse. Sampled only in IDLE.
- abort_i  in  1  active-high. Returns the block to IDLE from any state. No done_o is produced.
- n_i  in  IDX_W  requested prime index. 1 selects 2, 2 selects 3, and so on. Latched on an accepted start.
- busy_o  out  1  high in REQ, NEXT and DONE.
- done_o  out  1  one-cycle pulse when a result is ready.
- prime_o  out  W  result. Held from DONE until the next accepted start, reset or abort.
- ovf_o  out  1  result-status flag, valid with prime_o. High means the candidate range was exhausted.
- chk_req_o  out  1  checker request.
- chk_cand_o  out  W  candidate under test. Stable while chk_req_o is high.
- chk_ack_i  in  1  checker acknowledge. The verdict is valid in the same cycle.
- chk_is_prime_i  in  1  checker verdict. Meaningful only when chk_req_o and chk_ack_i are both high.

## Operation
- Registers: n_q (IDX_W), cnt_q (IDX_W), cand_q (W), isp_q (1), prime_q (W), ovf_q (1).
- FSM states are IDLE, REQ, NEXT and DONE.
- IDLE to REQ:
  - Condition: start_i=1 and n_i≠0.
  - Actions: n_q←n_i, cnt_q←0, cand_q←2, prime_q←0, ovf_q←0.
- IDLE to DONE:
  - Condition: start_i=1 and n_i=0.
  - Actions: prime_q←0, ovf_q←0. No checker traffic occurs.
- REQ:
  - chk_req_o=1 and chk_cand_o=cand_q.
  - When chk_ack_i=1: isp_q←chk_is_prime_i, then go to NEXT.
  - Otherwise stay in REQ, with request and candidate unchanged.
- NEXT:
  - chk_req_o=0.
  - If isp_q=1 and cnt_q+1=n_q: prime_q←cand_q, go to DONE.
  - Otherwise, if isp_q=1: cnt_q←cnt_q+1.
  - Otherwise, if cand_q=2^W−1: ovf_q←1, prime_q←0, go to DONE.
  - Otherwise: cand_q←cand_q+1, go to REQ.
- DONE: done_o=1 for this cycle only, then go to IDLE.
- Ignored inputs:
  - start_i outside IDLE is ignored, and n_i changes after acceptance have no effect.
  - chk_ack_i while chk_req_o=0 is ignored. Acks in NEXT, IDLE or DONE have no effect.
- Arithmetic:
  - The cnt_q compare is done at IDX_W+1 bits.
  - cand_q never wraps. Exhaustion is detected before the increment.
- Abort:
  - abort_i has priority over every transition except rst.
  - The next state is IDLE, and chk_req_o drops on the following cycle.
  - prime_q and ovf_q are cleared to 0.
  - abort_i and start_i together in IDLE result in IDLE, with start ignored.
- Reset:
  - Next state is IDLE.
  - busy_o=0, done_o=0, chk_req_o=0, chk_cand_o=0, prime_o=0, ovf_o=0.
  - This applies mid-search as well: everything clears and there is no done pulse.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from the checker or command inputs to outputs.
- Accepted start at edge t:
  - busy_o and chk_req_o go high in cycle t+1.
  - The first candidate is 2.
- Cost per candidate:
  - 1 REQ cycle plus wait cycles for the ack.
  - Plus 1 NEXT cycle, during which req is low. Back-to-back requests are therefore always separated by at least one idle cycle.
- Zero-wait checker (ack in the first REQ cycle):
  - done_o asserts in cycle t+1+2·C, where C is the number of candidates tested.
  - Example: N=1 gives done at t+3. N=0 gives done at t+1.
- Result timing:
  - prime_o and ovf_o are valid in the done_o cycle and hold afterwards.
  - busy_o drops in the cycle after done_o.
- Restart: a new start is accepted in the first IDLE cycle after DONE.

## Test plan
- Reset mid-search: assert rst while in REQ.
  - Next cycle: all outputs are 0, and the state is IDLE.
  - A subsequent start with n_i=2 yields prime_o=3.
- Zero-wait checker model (exact primality), W=8, n_i=1 started at t:
  - chk_cand_o=2 at t+1.
  - done_o at t+3, prime_o=2, ovf_o=0.
- Same model, n_i=5:
  - Candidates observed are 2,3,4,5,6,7,8,9,10,11, each request separated by a low cycle.
  - done_o at t+21, prime_o=11.
- Checker with a 3-cycle ack delay, n_i=3:
  - chk_cand_o stays stable across the wait cycles.
  - prime_o=5. Acks injected during NEXT and IDLE are ignored.
- Overflow and corner cases, W=4:
  - n_i=7 gives ovf_o=1 and prime_o=0 after candidate 15.
  - n_i=0 gives done_o at t+1 with no chk_req_o.
- abort_i during REQ with n_i=9:
  - Back to IDLE, with no done_o.
  - start_i pulsed while busy is ignored.
  - A new start with n_i=4 gives prime_o=7.

Source files
------------

// File: rtl/prime_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prime_seq_ctrl
//  Description : Finds the N-th prime by walking candidates upward from 2 and
//                handing each one to a shared trial-division checker through
//                a request/acknowledge handshake. Checker-confirmed primes
//                are counted until the N-th is reached. If the candidate
//                range runs out first, the block reports overflow.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start_i, abort_i    - command pulse / return-to-idle
//                n_i                 - requested prime index (1 -> 2)
//                busy_o, done_o      - search in progress / result strobe
//                prime_o, ovf_o      - result and range-exhausted flag
//                chk_req_o, chk_cand_o, chk_ack_i, chk_is_prime_i
//                                    - checker handshake
//  Revision    : 1.0  initial release
// ============================================================================
module prime_seq_ctrl #(
    parameter int W     = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [IDX_W-1:0] n_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [W-1:0]     prime_o,
    output logic             ovf_o,
    output logic             chk_req_o,
    output logic [W-1:0]     chk_cand_o,
    input  logic             chk_ack_i,
    input  logic             chk_is_prime_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_NEXT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [W-1:0] c_CAND_FIRST = W'(2);
    localparam logic [W-1:0] c_CAND_LAST  = {W{1'b1}};

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   n_q, n_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       cand_q, cand_d;
    logic               isp_q, isp_d;
    logic [W-1:0]       prime_q, prime_d;
    logic               ovf_q, ovf_d;

    // Prime count compared one bit wider so cnt_q+1 cannot alias back to a
    // small index when cnt_q sits at its maximum.
    logic [IDX_W:0]     w_cnt_inc;
    logic               w_hit;

    assign w_cnt_inc = {1'b0, cnt_q} + (IDX_W+1)'(1);
    assign w_hit     = (w_cnt_inc == {1'b0, n_q});

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        isp_d   = isp_q;
        prime_d = prime_q;
        ovf_d   = ovf_q;

        if (abort_i) begin
            state_d = S_IDLE;
            prime_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        prime_d = '0;
                        ovf_d   = 1'b0;
                        if (n_i != '0) begin
                            n_d     = n_i;
                            cnt_d   = '0;
                            cand_d  = c_CAND_FIRST;
                            state_d = S_REQ;
                        end else begin
                            // Index 0 has no prime: answer at once, no checker traffic.
                            state_d = S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (chk_ack_i) begin
                        isp_d   = chk_is_prime_i;
                        state_d = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (isp_q && w_hit) begin
                        prime_d = cand_q;
                        state_d = S_DONE;
                    end else begin
                        if (isp_q) begin
                            cnt_d = w_cnt_inc[IDX_W-1:0];
                        end
                        // Exhaustion is tested before the increment so cand_q never wraps.
                        if (cand_q == c_CAND_LAST) begin
                            ovf_d   = 1'b1;
                            prime_d = '0;
                            state_d = S_DONE;
                        end else begin
                            cand_d  = cand_q + W'(1);
                            state_d = S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            cand_q  <= '0;
            isp_q   <= 1'b0;
            prime_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            isp_q   <= isp_d;
            prime_q <= prime_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come only from the state register and data flops.
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign chk_req_o  = (state_q == S_REQ);
    assign chk_cand_o = (state_q == S_REQ) ? cand_q : '0;
    assign prime_o    = prime_q;
    assign ovf_o      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_prime_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prime_seq_ctrl
//  Description : Self-checking bench for prime_seq_ctrl. An 8-bit and a
//                4-bit instance are each driven by a checker responder that
//                has a configurable ack delay. Expected candidates and results
//                are queued when a start is issued. They are compared when
//                the DUT presents requests and done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prime_seq_ctrl;

    typedef struct {
        int prime;
        bit ovf;
        int cyc;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_v [2];
    logic       abort_v [2];
    logic [3:0] n_v     [2];
    logic       ack_v   [2];
    logic       isp_v   [2];

    logic       busy_a, done_a, ovf_a, req_a;
    logic [7:0] prime_a, cand_a;
    logic       busy_b, done_b, ovf_b, req_b;
    logic [3:0] prime_b, cand_b;

    logic       obs_req   [2];
    logic       obs_done  [2];
    logic       obs_busy  [2];
    logic       obs_ovf   [2];
    logic [7:0] obs_cand  [2];
    logic [7:0] obs_prime [2];

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   issued = 0;
    int   delay = 0;
    bit   spur = 1'b0;
    int   last_prime = 0;
    int   wait_c   [2];
    int   cur_exp  [2];
    logic prev_req [2];
    logic prev_ack [2];
    logic prev_done[2];

    int   cand_q [$];
    res_t res_q  [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    prime_seq_ctrl #(.W(8), .IDX_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .start_i(start_v[0]), .abort_i(abort_v[0]), .n_i(n_v[0]),
        .busy_o(busy_a), .done_o(done_a), .prime_o(prime_a), .ovf_o(ovf_a),
        .chk_req_o(req_a), .chk_cand_o(cand_a), .chk_ack_i(ack_v[0]), .chk_is_prime_i(isp_v[0])
    );

    prime_seq_ctrl #(.W(4), .IDX_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .start_i(start_v[1]), .abort_i(abort_v[1]), .n_i(n_v[1]),
        .busy_o(busy_b), .done_o(done_b), .prime_o(prime_b), .ovf_o(ovf_b),
        .chk_req_o(req_b), .chk_cand_o(cand_b), .chk_ack_i(ack_v[1]), .chk_is_prime_i(isp_v[1])
    );

    always_comb begin
        obs_req[0]   = req_a;   obs_req[1]   = req_b;
        obs_done[0]  = done_a;  obs_done[1]  = done_b;
        obs_busy[0]  = busy_a;  obs_busy[1]  = busy_b;
        obs_ovf[0]   = ovf_a;   obs_ovf[1]   = ovf_b;
        obs_cand[0]  = cand_a;  obs_cand[1]  = {4'b0, cand_b};
        obs_prime[0] = prime_a; obs_prime[1] = {4'b0, prime_b};
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++)
            if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor and checker responder; ack decided from the current request.
    always @(negedge clk) begin
        res_t r;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                prev_req[i]  = 1'b0;
                prev_ack[i]  = 1'b0;
                prev_done[i] = 1'b0;
            end else begin
                if (obs_req[i]) begin
                    if (prev_req[i]) begin
                        check_val("cand_stable", 32'(obs_cand[i]), cur_exp[i]);
                    end else if (cand_q.size() == 0) begin
                        check_val("cand_unexpected", 32'(obs_req[i]), 0);
                    end else begin
                        cur_exp[i] = cand_q.pop_front();
                        check_val("cand", 32'(obs_cand[i]), cur_exp[i]);
                    end
                end
                if (prev_req[i] && prev_ack[i])
                    check_val("req_gap", 32'(obs_req[i]), 0);
                if (obs_done[i]) begin
                    done_cnt++;
                    check_val("done_busy", 32'(obs_busy[i]), 1);
                    if (res_q.size() == 0) begin
                        check_val("done_unexpected", 32'(obs_done[i]), 0);
                    end else begin
                        r = res_q.pop_front();
                        last_prime = r.prime;
                        check_val("prime", 32'(obs_prime[i]), r.prime);
                        check_val("ovf", 32'(obs_ovf[i]), 32'(r.ovf));
                        if (r.cyc >= 0) check_val("done_cycle", cyc, r.cyc);
                    end
                end
                if (prev_done[i])
                    check_val("busy_drop", 32'(obs_busy[i]), 0);
            end

            if (obs_req[i]) begin
                if (wait_c[i] >= delay) begin
                    ack_v[i]  = 1'b1;
                    isp_v[i]  = is_prime(int'(obs_cand[i]));
                    wait_c[i] = 0;
                end else begin
                    ack_v[i]  = 1'b0;
                    isp_v[i]  = 1'b1;
                    wait_c[i] = wait_c[i] + 1;
                end
            end else begin
                ack_v[i]  = spur;
                isp_v[i]  = spur;
                wait_c[i] = 0;
            end

            if (!rst) begin
                prev_req[i]  = obs_req[i];
                prev_ack[i]  = obs_req[i] && ack_v[i];
                prev_done[i] = obs_done[i];
            end
        end
    end

    // Called on a negedge: queue the expected candidates/result, pulse start,
    // then scramble n_i so a late re-sample would be visible.
    task automatic issue(input int inst, input int n, input bit want);
        int   w;
        int   c;
        int   cnt;
        bit   found;
        res_t r;
        w = (inst == 0) ? 8 : 4;
        c = 0;
        cnt = 0;
        found = 1'b0;
        r.prime = 0;
        r.ovf = 1'b0;
        if (n != 0) begin
            for (int cd = 2; cd < (1 << w) && !found; cd++) begin
                cand_q.push_back(cd);
                c++;
                if (is_prime(cd)) begin
                    cnt++;
                    if (cnt == n) begin
                        r.prime = cd;
                        found = 1'b1;
                    end
                end
            end
            if (!found) r.ovf = 1'b1;
        end
        r.cyc = (delay == 0) ? cyc + 1 + 2 * c : -1;
        if (want) begin
            res_q.push_back(r);
            issued++;
        end
        start_v[inst] = 1'b1;
        n_v[inst] = n[3:0];
        @(negedge clk);
        start_v[inst] = 1'b0;
        n_v[inst] = ~n_v[inst];
    endtask

    task automatic wait_done(input int inst);
        int k;
        k = 0;
        while (done_cnt < issued && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_val("done_timeout", 32'(done_cnt >= issued), 1);
        repeat (2) @(negedge clk);
        check_val("prime_hold", 32'(obs_prime[inst]), last_prime);
    endtask

    task automatic wait_req(input int inst);
        int k;
        k = 0;
        while (!obs_req[inst] && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_val("req_timeout", 32'(obs_req[inst]), 1);
    endtask

    initial begin
        int c0;
        int d0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
            n_v[i]     = 4'd0;
            wait_c[i]  = 0;
            cur_exp[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_val("rst_busy",  32'(busy_a),  0);
        check_val("rst_done",  32'(done_a),  0);
        check_val("rst_req",   32'(req_a),   0);
        check_val("rst_cand",  32'(cand_a),  0);
        check_val("rst_prime", 32'(prime_a), 0);
        check_val("rst_ovf",   32'(ovf_a),   0);
        rst = 1'b0;
        @(negedge clk);

        // N=1 zero-wait, then restart in the first IDLE cycle after DONE.
        c0 = cyc;
        issue(0, 1, 1'b1);
        while (cyc < c0 + 4) @(negedge clk);
        issue(0, 2, 1'b1);
        wait_done(0);

        // N=5 zero-wait: ten candidates, done at t+21.
        issue(0, 5, 1'b1);
        wait_done(0);

        // 3-cycle ack delay with stray acks outside REQ.
        delay = 3;
        spur = 1'b1;
        issue(0, 3, 1'b1);
        wait_done(0);
        spur = 1'b0;
        delay = 0;

        // abort together with start in IDLE: start dropped, held result cleared.
        abort_v[0] = 1'b1;
        start_v[0] = 1'b1;
        n_v[0] = 4'd4;
        @(negedge clk);
        abort_v[0] = 1'b0;
        start_v[0] = 1'b0;
        check_val("abort_idle_busy",  32'(busy_a),  0);
        check_val("abort_idle_prime", 32'(prime_a), 0);
        check_val("abort_idle_req",   32'(req_a),   0);

        // abort during REQ with n=9, with a start pulsed while busy.
        delay = 4;
        issue(0, 9, 1'b0);
        start_v[0] = 1'b1;
        n_v[0] = 4'd1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_req(0);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        check_val("abort_req",   32'(req_a),   0);
        check_val("abort_busy",  32'(busy_a),  0);
        check_val("abort_done",  32'(done_a),  0);
        check_val("abort_prime", 32'(prime_a), 0);
        cand_q.delete();
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check_val("abort_no_done", done_cnt, d0);
        check_val("abort_stay_idle", 32'(busy_a), 0);
        delay = 0;
        issue(0, 4, 1'b1);
        wait_done(0);

        // Reset in the middle of a search.
        delay = 2;
        issue(0, 5, 1'b0);
        wait_req(0);
        rst = 1'b1;
        @(negedge clk);
        check_val("mrst_busy",  32'(busy_a),  0);
        check_val("mrst_done",  32'(done_a),  0);
        check_val("mrst_req",   32'(req_a),   0);
        check_val("mrst_cand",  32'(cand_a),  0);
        check_val("mrst_prime", 32'(prime_a), 0);
        check_val("mrst_ovf",   32'(ovf_a),   0);
        rst = 1'b0;
        cand_q.delete();
        delay = 0;
        @(negedge clk);
        issue(0, 2, 1'b1);
        wait_done(0);

        // 4-bit instance: range exhaustion after candidate 15, and N=0.
        issue(1, 7, 1'b1);
        wait_done(1);
        issue(1, 0, 1'b1);
        wait_done(1);

        check_val("cand_queue_empty", 32'(cand_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
